// File: rtl/alu_shift_pkg.sv
// alu_shift_pkg: shared definitions for the multi-cycle shift/rotate unit.
//   shift_mode_e : operation encoding (SHL, SHR, SHRA, ROL, ROR)
//   ST_*         : controller state encoding
//   shamt_width  : derives the shift-amount field width from the datapath width
package alu_shift_pkg;

    typedef enum logic [2:0] {
        MODE_SHL  = 3'd0,
        MODE_SHR  = 3'd1,
        MODE_SHRA = 3'd2,
        MODE_ROL  = 3'd3,
        MODE_ROR  = 3'd4
    } shift_mode_e;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic int shamt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/alu_shift_unit_shift_step.sv
// shift_step: combinational single-iteration shifter/rotator.
//   word_i    : current working word
//   k_i       : positions to move this iteration (0..STEP)
//   mode_i    : operation
//   fill_i    : fill bit for SHRA (original operand MSB)
//   word_o    : shifted/rotated word
//   out_bit_o : last bit that left the word (0 when k_i = 0)
module shift_step
    import alu_shift_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = shamt_width(WIDTH)
) (
    input  logic [WIDTH-1:0]   word_i,
    input  logic [SHAMT_W-1:0] k_i,
    input  shift_mode_e        mode_i,
    input  logic               fill_i,
    output logic [WIDTH-1:0]   word_o,
    output logic               out_bit_o
);

    logic [WIDTH-1:0] left_spill;
    logic [WIDTH-1:0] right_spill;
    logic [WIDTH-1:0] fill_mask;

    // A shift by WIDTH yields zero, so k_i = 0 naturally leaves the word
    // untouched and produces no spill bits.
    always_comb begin
        left_spill  = word_i >> (WIDTH - int'(k_i));
        right_spill = word_i << (WIDTH - int'(k_i));
        fill_mask   = {WIDTH{fill_i}} << (WIDTH - int'(k_i));
        word_o      = word_i << k_i;
        out_bit_o   = left_spill[0];
        unique case (mode_i)
            MODE_SHR: begin
                word_o    = word_i >> k_i;
                out_bit_o = right_spill[WIDTH-1];
            end
            MODE_SHRA: begin
                word_o    = (word_i >> k_i) | fill_mask;
                out_bit_o = right_spill[WIDTH-1];
            end
            MODE_ROL: begin
                word_o    = (word_i << k_i) | left_spill;
                out_bit_o = left_spill[0];
            end
            MODE_ROR: begin
                word_o    = (word_i >> k_i) | right_spill;
                out_bit_o = right_spill[WIDTH-1];
            end
            default: begin
                word_o    = word_i << k_i;
                out_bit_o = left_spill[0];
            end
        endcase
    end

endmodule

// File: rtl/alu_shift_unit.sv
// alu_shift_unit: multi-cycle shift/rotate unit, up to STEP positions per clock.
//   Clock, Clear : system clock, synchronous active-high clear
//   start        : request, taken only in IDLE
//   mode, A      : operation (codes 5-7 run as SHL) and operand
//   shamt        : shift amount, 0..WIDTH-1
//   result       : working/result register, valid while done=1 and held after
//   busy, done   : high in RUN / one-cycle completion pulse
//   carry, zero  : last bit shifted out / result==0 (only with SHIFT_FLAGS_EN)
// Optional feature macro: SHIFT_FLAGS_EN.
//
// state   | meaning
// IDLE    | waiting for start; result held
// RUN     | shifting min(count,STEP) positions per clock
// DONE    | done pulse for one cycle, then back to IDLE
module alu_shift_unit
    import alu_shift_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int STEP    = 1,
    parameter int SHAMT_W = shamt_width(WIDTH)
) (
    input  logic               Clock,
    input  logic               Clear,
    input  logic               start,
    input  logic [2:0]         mode,
    input  logic [WIDTH-1:0]   A,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [WIDTH-1:0]   result,
    output logic               busy,
    output logic               done
`ifdef SHIFT_FLAGS_EN
    ,
    output logic               carry,
    output logic               zero
`endif
);

    logic [1:0]         state_q,  state_d;
    logic [SHAMT_W-1:0] count_q,  count_d;
    logic [WIDTH-1:0]   result_q, result_d;
    shift_mode_e        mode_q,   mode_d;
    logic               fill_q,   fill_d;

    logic [SHAMT_W-1:0] step_k;
    logic [WIDTH-1:0]   step_word;
    logic               step_out;

    // STEP may equal WIDTH and not fit the count field; that arm is then
    // unreachable because count is always below WIDTH.
    always_comb begin
        step_k = (int'(count_q) < STEP) ? count_q : SHAMT_W'(STEP);
    end

    shift_step #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_step (
        .word_i    (result_q),
        .k_i       (step_k),
        .mode_i    (mode_q),
        .fill_i    (fill_q),
        .word_o    (step_word),
        .out_bit_o (step_out)
    );

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        result_d = result_q;
        mode_d   = mode_q;
        fill_d   = fill_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    result_d = A;
                    count_d  = shamt;
                    fill_d   = A[WIDTH-1];
                    mode_d   = (mode > 3'd4) ? MODE_SHL : shift_mode_e'(mode);
                    state_d  = (shamt == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                result_d = step_word;
                count_d  = count_q - step_k;
                if (count_q == step_k) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Clear) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            result_q <= '0;
            mode_q   <= MODE_SHL;
            fill_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            result_q <= result_d;
            mode_q   <= mode_d;
            fill_q   <= fill_d;
        end
    end

    assign result = result_q;
    assign busy   = (state_q == ST_RUN);
    assign done   = (state_q == ST_DONE);

`ifdef SHIFT_FLAGS_EN
    logic carry_q, carry_d;
    logic zero_q,  zero_d;

    // zero is captured from the value result takes on the edge into DONE.
    always_comb begin
        carry_d = carry_q;
        zero_d  = zero_q;
        if (state_q == ST_IDLE && start) begin
            carry_d = 1'b0;
            if (shamt == '0) zero_d = (A == '0);
        end else if (state_q == ST_RUN) begin
            carry_d = step_out;
            if (count_q == step_k) zero_d = (step_word == '0);
        end
    end

    always_ff @(posedge Clock) begin
        if (Clear) begin
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

    assign carry = carry_q;
    assign zero  = zero_q;
`else
    wire unused_step_out = step_out;
`endif

endmodule

// File: doc/alu_shift_unit.md
# alu_shift_unit

Parametrised multi-cycle shift/rotate unit for the Mini SRC ALU, replacing the single-cycle SHL path between the Y/bus operands and the Z register. It accepts an operand and shift amount on a start pulse and iterates up to STEP bit positions per clock. It supports SHL, SHR, SHRA, ROL and ROR, and reports completion with a one-cycle done pulse. The control sequencer stalls its Zlow-load step on busy and captures result into ZLow on done.

## Interface
- WIDTH, 32, datapath width in bits; must be at least 2.
- STEP, 1, maximum bit positions shifted per cycle; must be a power of two, ≤ WIDTH.
- SHAMT_W, $clog2(WIDTH), width of the shift-amount field (derived; do not override).

- Clock  in  1  single system clock; all state changes on its rising edge.
- Clear  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only while state is IDLE.
- mode  in  3  operation: SHL=0, SHR=1, SHRA=2, ROL=3, ROR=4; codes 5–7 are reserved.
- A  in  WIDTH  operand to shift.
- shamt  in  SHAMT_W  shift amount; the caller passes the low SHAMT_W bits of the amount register.
- result  out  WIDTH  working/result register; valid while done=1 and held until the next accepted start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle completion pulse.
- carry  out  1  (SHIFT_FLAGS_EN only) last bit shifted or rotated out.
- zero  out  1  (SHIFT_FLAGS_EN only) result equals 0.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - On start, latch A into result, latch mode, and set count=shamt.
  - If shamt=0, go to DONE; otherwise go to RUN.
  - Reserved mode codes are latched as SHL.
- **RUN**
  - Each cycle, shift result by k=min(count,STEP) according to mode, then set count=count−k.
  - When the new count=0, go to DONE.
- **DONE**
  - done=1 for this cycle only, then go to IDLE.
  - result is unchanged in DONE and IDLE.
- **Shift rules**
  - SHL and SHR zero-fill.
  - SHRA fills with the original A[WIDTH-1].
  - ROL and ROR wrap bits around; shamt equal to a multiple of WIDTH cannot occur, because shamt < WIDTH.
- **Boundary conditions**
  - start while busy or in DONE is ignored. No queueing; the requester must re-assert start.
  - Inputs A, shamt and mode are don't-care after the accept edge.
  - Clear is synchronous and overrides everything, including start in the same cycle. It forces the state to IDLE, and result, count, busy, done, carry and zero to 0.
  - Clear in the middle of RUN abandons the operation with no done pulse.
- **Reset values:** result=0, busy=0, done=0, carry=0, zero=0.

## Timing
- Let edge 0 be the edge that samples start=1 in IDLE, and N=ceil(shamt/STEP).
- The state enters RUN after edge 0, and busy is high from edge 0 until edge N.
- done is high for exactly the cycle following edge N; for shamt=0 that is the cycle following edge 0 (N=0).
- The next start is accepted at the earliest at edge N+2; a start held high in DONE is taken at edge N+2.
- Worst-case latency is ceil((WIDTH−1)/STEP) cycles plus the done cycle.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- SHIFT_FLAGS_EN defined:
  - carry and zero ports exist.
  - carry is updated on each RUN step to the last bit that left the word: result[WIDTH−k] for SHL, result[k−1] for SHR/SHRA/ROR, and the wrapped MSB for ROL.
  - carry is 0 when shamt=0.
  - zero is registered alongside result when entering DONE.
- SHIFT_FLAGS_EN undefined: the ports and their logic are absent; all other behaviour is identical.

## Structure
- Shared package alu_shift_pkg contains:
  - the mode encodings as a typedef enum (SHL..ROR);
  - the state encoding (IDLE, RUN, DONE);
  - a localparam helper for SHAMT_W.
- Sub-module shift_step: combinational, shifts/rotates a WIDTH-bit word by k (0..STEP) for a given mode, and outputs the bit shifted out. It is instantiated once inside alu_shift_unit.

## Test plan
- WIDTH=32, STEP=1: SHL, A=0x00000004, shamt=2 -> busy high for 2 cycles, done in cycle 3, result=0x00000010.
- SHRA, A=0x80000000, shamt=4 -> result=0xF8000000 after 4 RUN cycles. SHR with the same inputs -> 0x08000000.
- ROR, A=0x00000027, shamt=8 -> 0x27000000. ROL, A=0x80000001, shamt=1 -> 0x00000003.
- shamt=0, any mode, A=0xDEADBEEF -> done in the cycle after start, busy never high, result=0xDEADBEEF.
- STEP=8: SHL, A=0x1, shamt=31 -> exactly 4 RUN cycles, result=0x80000000. A second start issued during RUN is ignored; result remains from the first operation.
- Clear on RUN cycle 2 of a shamt=6 SHL -> next cycle all outputs are 0 and there is no done pulse. With SHIFT_FLAGS_EN: SHL, A=0x80000001, shamt=1 -> result=0x00000002, carry=1, zero=0.
